axis_header_extract: RTL and testbench
======================================

# axis_header_extract

Downstream stage of the market-data cut-through filter. Consumes the filter's forwarded AXI-stream packets, passes every beat on through a registered 2-entry skid slice, and extracts one header record per packet (message type, symbol, price, beat count). Records are queued in a small first-word-fall-through FIFO for the strategy logic. Backpressure is honoured on all three interfaces.

## Interface
- WIDTH, 64: stream data width in bits; only 64 is supported.
- HDR_DEPTH, 4: header FIFO depth in records; must be a power of two and at least 2.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- slave_tdata  in  WIDTH  input beat data.
- slave_byteEnable  in  WIDTH/8  input byte enables; passed through unchanged.
- slave_tvalid  in  1  input beat valid.
- slave_tlast  in  1  last beat of packet.
- slave_tready  out  1  input ready; driven from registered state only.
- master_tdata  out  WIDTH  output beat data.
- master_byteEnable  out  WIDTH/8  output byte enables.
- master_tvalid  out  1  output beat valid.
- master_tlast  out  1  output last beat.
- master_tready  in  1  downstream ready.
- hdr_valid  out  1  FIFO head record is valid.
- hdr_ready  in  1  consumer accepts the head record.
- hdr_msg_type  out  8  header beat bits [63:56].
- hdr_symbol_id  out  24  header beat bits [55:32].
- hdr_price_q16_16  out  32  header beat bits [31:0].
- hdr_beats  out  16  packet length in beats; saturates at 16'hFFFF.
- stat_pkts  out  32  packets whose header was queued (see Configuration).
- stat_stall_cycles  out  32  cycles stalled by a full header FIFO (see Configuration).

## Operation
- Input beats are accepted when slave_tvalid && slave_tready.
- slave_tready = skid_ready_q && (fifo_count != HDR_DEPTH). The whole stream is stalled while the FIFO is full, including mid-packet beats.
- Skid slice: 2 entries.
  - master_* are driven from the main register.
  - skid_ready_q deasserts when the overflow register is occupied.
  - No beat is lost or duplicated under any master_tready pattern.
- Parser FSM, advanced only on an accepted beat:
  - IDLE: capture bits [63:56], [55:32] and [31:0] of the beat; set beat_cnt = 1.
    - If tlast is set: push the record with beats = 1 and stay in IDLE.
    - Otherwise: go to IN_PKT.
  - IN_PKT: beat_cnt increments, saturating at 16'hFFFF. On tlast, push the record with the final count and go to IDLE.
- Header FIFO:
  - Pop on hdr_valid && hdr_ready.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - hdr_* show the head record; their values are don't-care while hdr_valid = 0.
- Reset, asynchronous, may occur mid-packet:
  - FSM returns to IDLE.
  - Any partial header is discarded.
  - Skid and FIFO are emptied.
  - Counters are cleared.

## Timing
- Reset values:
  - slave_tready = 0, master_tvalid = 0, master_tlast = 0, master_tdata = 0, master_byteEnable = 0.
  - hdr_valid = 0, hdr_* = 0, stat_* = 0.
- slave_tready rises on the first clk edge after rst deasserts.
- Stream latency: a beat accepted at edge N appears on master_* after edge N.
  - Throughput is 1 beat/cycle with master_tready held high.
- Header latency: the tlast beat accepted at edge N gives hdr_valid = 1 after edge N. This holds for single-beat packets as well.
- Full FIFO: when count = HDR_DEPTH, slave_tready = 0 in that cycle even if hdr_ready = 1. Input resumes the cycle after the pop.
- master_tvalid, once asserted, holds with stable data until master_tready is seen.

## Configuration
- HDREXT_STATS_EN, when defined:
  - stat_pkts increments on each FIFO push.
  - stat_stall_cycles increments each cycle with slave_tvalid = 1 and fifo_count = HDR_DEPTH.
  - Both counters wrap modulo 2^32.
- When undefined: both ports are tied to 0 and no counter logic is synthesized.

## Test plan
- Single 3-beat packet, beat0 = 64'h54_414150_0064_8000, master_tready = 1, hdr_ready = 1:
  - Beats appear 1 cycle later, unchanged.
  - One record: msg_type 8'h54, symbol 24'h414150, price 32'h00648000, beats 3.
- Single-beat packet with tlast on beat0 -> record with beats 1; FSM stays in IDLE.
- hdr_ready = 0, five back-to-back 2-beat packets, HDR_DEPTH = 4:
  - slave_tready drops after the 4th tlast.
  - Raising hdr_ready pops records in order.
  - The 5th packet then completes and its record follows.
  - stat_stall_cycles > 0 when HDREXT_STATS_EN is defined.
- Random master_tready toggling (50%) over 1000 beats -> output sequence identical to input, no drops or duplicates, tvalid/tdata stable while stalled.
- rst pulsed after beat 2 of a 4-beat packet:
  - All outputs return to reset values.
  - No record is emitted.
  - The next packet parses from IDLE correctly.
- 70000-beat packet -> hdr_beats = 16'hFFFF.

Source files
------------

// File: rtl/axis_header_extract.sv
`default_nettype none
// ============================================================================
// Module   : axis_header_extract
// Purpose  : Forwards an AXI-stream through a registered 2-entry skid slice
//            and extracts one header record per packet (msg type, symbol,
//            price, beat count) into a first-word-fall-through FIFO.
// Ports    : clk, rst (async, active-high)
//            slave_*  - input stream (tdata, byteEnable, tvalid, tlast, tready)
//            master_* - output stream (same fields, registered)
//            hdr_*    - header record FIFO head (valid/ready handshake)
//            stat_*   - packet / full-FIFO stall counters
// Options  : `define HDREXT_STATS_EN to build the statistics counters;
//            otherwise stat_* are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module axis_header_extract #(
  parameter int WIDTH     = 64,
  parameter int HDR_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     slave_tdata,
  input  logic [WIDTH/8-1:0]   slave_byteEnable,
  input  logic                 slave_tvalid,
  input  logic                 slave_tlast,
  output logic                 slave_tready,
  output logic [WIDTH-1:0]     master_tdata,
  output logic [WIDTH/8-1:0]   master_byteEnable,
  output logic                 master_tvalid,
  output logic                 master_tlast,
  input  logic                 master_tready,
  output logic                 hdr_valid,
  input  logic                 hdr_ready,
  output logic [7:0]           hdr_msg_type,
  output logic [23:0]          hdr_symbol_id,
  output logic [31:0]          hdr_price_q16_16,
  output logic [15:0]          hdr_beats,
  output logic [31:0]          stat_pkts,
  output logic [31:0]          stat_stall_cycles
);

  localparam int BEW  = WIDTH / 8;
  localparam int PW   = $clog2(HDR_DEPTH);
  localparam int CW   = PW + 1;
  localparam int RECW = 80;
  localparam logic [CW-1:0] FULL_CNT = CW'(HDR_DEPTH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_IN_PKT = 1'b1;

  // ---------------------------------------------------------------- skid
  logic [WIDTH-1:0] main_data_q, main_data_d, ovf_data_q, ovf_data_d;
  logic [BEW-1:0]   main_be_q, main_be_d, ovf_be_q, ovf_be_d;
  logic             main_last_q, main_last_d, ovf_last_q, ovf_last_d;
  logic             main_valid_q, main_valid_d, ovf_valid_q, ovf_valid_d;
  logic             skid_ready_q, skid_ready_d;
  logic [CW-1:0]    fifo_count_q, fifo_count_d;
  logic             accept;
  logic             main_take;

  assign slave_tready = skid_ready_q && (fifo_count_q != FULL_CNT);
  assign accept       = slave_tvalid && slave_tready;
  assign main_take    = !main_valid_q || master_tready;

  always_comb begin
    main_data_d  = main_data_q;
    main_be_d    = main_be_q;
    main_last_d  = main_last_q;
    main_valid_d = main_valid_q;
    ovf_data_d   = ovf_data_q;
    ovf_be_d     = ovf_be_q;
    ovf_last_d   = ovf_last_q;
    ovf_valid_d  = ovf_valid_q;
    if (main_take) begin
      // A parked overflow beat always goes first; no input can be accepted
      // in that cycle because skid_ready_q is low while it is occupied.
      if (ovf_valid_q) begin
        main_data_d  = ovf_data_q;
        main_be_d    = ovf_be_q;
        main_last_d  = ovf_last_q;
        main_valid_d = 1'b1;
        ovf_valid_d  = 1'b0;
      end else if (accept) begin
        main_data_d  = slave_tdata;
        main_be_d    = slave_byteEnable;
        main_last_d  = slave_tlast;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      ovf_data_d  = slave_tdata;
      ovf_be_d    = slave_byteEnable;
      ovf_last_d  = slave_tlast;
      ovf_valid_d = 1'b1;
    end
    skid_ready_d = !ovf_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_q  <= '0;
      main_be_q    <= '0;
      main_last_q  <= 1'b0;
      main_valid_q <= 1'b0;
      ovf_data_q   <= '0;
      ovf_be_q     <= '0;
      ovf_last_q   <= 1'b0;
      ovf_valid_q  <= 1'b0;
      skid_ready_q <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_be_q    <= main_be_d;
      main_last_q  <= main_last_d;
      main_valid_q <= main_valid_d;
      ovf_data_q   <= ovf_data_d;
      ovf_be_q     <= ovf_be_d;
      ovf_last_q   <= ovf_last_d;
      ovf_valid_q  <= ovf_valid_d;
      skid_ready_q <= skid_ready_d;
    end
  end

  assign master_tdata      = main_data_q;
  assign master_byteEnable = main_be_q;
  assign master_tlast      = main_last_q;
  assign master_tvalid     = main_valid_q;

  // -------------------------------------------------------------- parser
  logic [0:0]  state_q, state_d;
  logic [15:0] beat_cnt_q, beat_cnt_d, cnt_inc;
  logic [63:0] hdr_word_q, hdr_word_d;
  logic        push;
  logic [RECW-1:0] push_rec;

  assign cnt_inc = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    hdr_word_d = hdr_word_q;
    push       = 1'b0;
    push_rec   = {hdr_word_q, cnt_inc};
    if (accept) begin
      if (state_q == S_IDLE) begin
        hdr_word_d = slave_tdata[63:0];
        beat_cnt_d = 16'd1;
        if (slave_tlast) begin
          push     = 1'b1;
          push_rec = {slave_tdata[63:0], 16'd1};
        end else begin
          state_d = S_IN_PKT;
        end
      end else begin
        beat_cnt_d = cnt_inc;
        if (slave_tlast) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      hdr_word_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      hdr_word_q <= hdr_word_d;
    end
  end

  // ---------------------------------------------------------- header FIFO
  // A push can only occur on an accepted beat, which already implies the
  // FIFO is not full, so no overflow guard is needed on the write side.
  logic [RECW-1:0] mem_q [HDR_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            pop;

  assign hdr_valid = (fifo_count_q != '0);
  assign pop       = hdr_valid && hdr_ready;

  always_comb begin
    fifo_count_d = fifo_count_q;
    if (push && !pop)      fifo_count_d = fifo_count_q + 1'b1;
    else if (!push && pop) fifo_count_d = fifo_count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HDR_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_rec;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_count_q <= fifo_count_d;
    end
  end

  assign {hdr_msg_type, hdr_symbol_id, hdr_price_q16_16, hdr_beats} = mem_q[rd_ptr_q];

  // ----------------------------------------------------------- statistics
`ifdef HDREXT_STATS_EN
  logic [31:0] stat_pkts_q, stat_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (push) stat_pkts_q <= stat_pkts_q + 32'd1;
      if (slave_tvalid && (fifo_count_q == FULL_CNT)) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_pkts         = stat_pkts_q;
  assign stat_stall_cycles = stat_stall_q;
`else
  assign stat_pkts         = 32'd0;
  assign stat_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_header_extract.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_header_extract
// Purpose  : Scoreboard bench for axis_header_extract. Stimulus pushes the
//            expected output beats and header records into queues; a monitor
//            on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_header_extract;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] slave_tdata = '0;
  logic [7:0]  slave_byteEnable = '0;
  logic        slave_tvalid = 1'b0;
  logic        slave_tlast = 1'b0;
  logic        slave_tready;
  logic [63:0] master_tdata;
  logic [7:0]  master_byteEnable;
  logic        master_tvalid;
  logic        master_tlast;
  logic        master_tready = 1'b1;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [7:0]  hdr_msg_type;
  logic [23:0] hdr_symbol_id;
  logic [31:0] hdr_price_q16_16;
  logic [15:0] hdr_beats;
  logic [31:0] stat_pkts;
  logic [31:0] stat_stall_cycles;

  axis_header_extract #(.WIDTH(64), .HDR_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .slave_tdata(slave_tdata), .slave_byteEnable(slave_byteEnable),
    .slave_tvalid(slave_tvalid), .slave_tlast(slave_tlast), .slave_tready(slave_tready),
    .master_tdata(master_tdata), .master_byteEnable(master_byteEnable),
    .master_tvalid(master_tvalid), .master_tlast(master_tlast), .master_tready(master_tready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_msg_type(hdr_msg_type), .hdr_symbol_id(hdr_symbol_id),
    .hdr_price_q16_16(hdr_price_q16_16), .hdr_beats(hdr_beats),
    .stat_pkts(stat_pkts), .stat_stall_cycles(stat_stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [72:0] sq[$];   // {data, byteEnable, last}
  logic [79:0] hq[$];   // {msg_type, symbol, price, beats}
  logic [79:0] last_hdr = '0;

  // bench-side packet model
  bit          m_in_pkt = 0;
  logic [63:0] m_word = '0;
  logic [15:0] m_cnt = '0;
  int          npkts = 0;

  bit rand_mt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_mt) master_tready = ($urandom_range(0, 1) == 1);
  end

  // monitor
  bit          pv = 0, pr = 0;
  logic [72:0] pd = '0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 128'(master_tvalid), 128'(1));
        chk("hold_data", 128'({master_tdata, master_byteEnable, master_tlast}), 128'(pd));
      end
      if (master_tvalid && master_tready) begin
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_beat: got %0h expected none", master_tdata);
        end else begin
          chk("beat", 128'({master_tdata, master_byteEnable, master_tlast}), 128'(sq.pop_front()));
        end
      end
      pv = master_tvalid; pr = master_tready;
      pd = {master_tdata, master_byteEnable, master_tlast};
      if (hdr_valid && hdr_ready) begin
        last_hdr = {hdr_msg_type, hdr_symbol_id, hdr_price_q16_16, hdr_beats};
        if (hq.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_hdr: got %0h expected none", last_hdr);
        end else begin
          chk("hdr", 128'(last_hdr), 128'(hq.pop_front()));
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] be, input logic l);
    int t;
    @(negedge clk);
    slave_tdata = d; slave_byteEnable = be; slave_tlast = l; slave_tvalid = 1'b1;
    t = 0;
    while (!slave_tready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!slave_tready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got tready=0 expected tready=1");
      slave_tvalid = 1'b0;
    end else begin
      sq.push_back({d, be, l});
      if (!m_in_pkt) begin
        m_word = d; m_cnt = 16'd1;
      end else begin
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      end
      if (l) begin
        hq.push_back({m_word, m_cnt});
        npkts++;
      end
      m_in_pkt = !l;
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    slave_tvalid = 1'b0; slave_tlast = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sq.size() != 0 || hq.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", 128'(sq.size() + hq.size()), 128'(0));
    @(negedge clk);
  endtask

  task automatic chk_stats();
`ifdef HDREXT_STATS_EN
    chk("stat_pkts", 128'(stat_pkts), 128'(npkts));
`else
    chk("stat_pkts_tied", 128'(stat_pkts), 128'(0));
    chk("stat_stall_tied", 128'(stat_stall_cycles), 128'(0));
`endif
  endtask

  task automatic chk_reset_vals();
    chk("rst_tready", 128'(slave_tready), 128'(0));
    chk("rst_master", 128'({master_tvalid, master_tlast, master_tdata, master_byteEnable}), 128'(0));
    chk("rst_hdr", 128'({hdr_valid, hdr_msg_type, hdr_symbol_id, hdr_price_q16_16, hdr_beats}), 128'(0));
    chk("rst_stats", 128'({stat_pkts, stat_stall_cycles}), 128'(0));
  endtask

  initial begin
    logic [63:0] d;
    int plen, k;
    // ---------------- reset
    #1;
    chk_reset_vals();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("tready_before_edge", 128'(slave_tready), 128'(0));
    @(posedge clk); #1;
    chk("tready_after_edge", 128'(slave_tready), 128'(1));

    // ---------------- 3-beat packet, latency check
    send_beat(64'h54_414150_00648000, 8'hFF, 1'b0);
    #1 chk("lat_b0", 128'({master_tvalid, master_tdata}), 128'({1'b1, 64'h54_414150_00648000}));
    send_beat(64'h1111_2222_3333_4444, 8'h0F, 1'b0);
    #1 chk("lat_b1", 128'({master_tvalid, master_tdata}), 128'({1'b1, 64'h1111_2222_3333_4444}));
    send_beat(64'h5555_6666_7777_8888, 8'hF0, 1'b1);
    #1 chk("hdr_lat", 128'(hdr_valid), 128'(1));
    idle();
    drain();
    chk("rec_3beat", 128'(last_hdr), 128'({8'h54, 24'h414150, 32'h00648000, 16'd3}));

    // ---------------- single-beat packet, then a 2-beat one parses from IDLE
    send_beat(64'hA1_B2C3D4_01020304, 8'hFF, 1'b1);
    #1 chk("hdr_lat_1beat", 128'(hdr_valid), 128'(1));
    idle();
    drain();
    chk("rec_1beat", 128'(last_hdr), 128'({8'hA1, 24'hB2C3D4, 32'h01020304, 16'd1}));
    send_beat(64'h42_000001_0000FFFF, 8'hFF, 1'b0);
    send_beat(64'h0, 8'h01, 1'b1);
    idle();
    drain();
    chk("rec_after_1beat", 128'(last_hdr), 128'({8'h42, 24'h000001, 32'h0000FFFF, 16'd2}));
    chk_stats();

    // ---------------- full FIFO with hdr_ready low
    @(posedge clk); #1 hdr_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      send_beat({8'(p + 1), 24'hC0FFEE, 32'(p * 100)}, 8'hFF, 1'b0);
      send_beat(64'(p), 8'hFF, 1'b1);
    end
    #1;
    chk("full_tready", 128'(slave_tready), 128'(0));
    chk("full_head", 128'({hdr_valid, hdr_msg_type}), 128'({1'b1, 8'h01}));
    fork
      begin
        send_beat({8'h05, 24'hC0FFEE, 32'd400}, 8'hFF, 1'b0);
        send_beat(64'd4, 8'hFF, 1'b1);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("full_still_stalled", 128'(slave_tready), 128'(0));
`ifdef HDREXT_STATS_EN
        chk("stall_cnt_nonzero", 128'(stat_stall_cycles != 0), 128'(1));
`endif
        hdr_ready = 1'b1;
      end
    join
    drain();
    chk("rec_5th", 128'(last_hdr), 128'({8'h05, 24'hC0FFEE, 32'd400, 16'd2}));
    chk_stats();

    // ---------------- random backpressure, 1000 beats
    rand_mt = 1;
    plen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (plen == 0) plen = $urandom_range(1, 8);
      d = {$urandom, $urandom};
      plen--;
      send_beat(d, 8'($urandom), (plen == 0) || (i == 999));
      if (i == 999) plen = 0;
    end
    idle();
    rand_mt = 0;
    @(posedge clk); #1 master_tready = 1'b1;
    drain();
    chk_stats();

    // ---------------- reset mid-packet
    send_beat(64'h77_ABCDEF_11111111, 8'hFF, 1'b0);
    send_beat(64'h2, 8'hFF, 1'b0);
    #2 rst = 1'b1;
    sq.delete(); hq.delete();
    m_in_pkt = 0; npkts = 0;
    slave_tvalid = 1'b0; slave_tlast = 1'b0;
    #1 chk_reset_vals();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_rst", 128'(slave_tready), 128'(1));
    chk("no_rec_after_rst", 128'(hdr_valid), 128'(0));
    send_beat(64'h33_000042_00010000, 8'hFF, 1'b0);
    send_beat(64'h9, 8'hFF, 1'b1);
    idle();
    drain();
    chk("rec_post_rst", 128'(last_hdr), 128'({8'h33, 24'h000042, 32'h00010000, 16'd2}));
    chk_stats();

    // ---------------- 70000-beat packet saturates the beat count
    k = 70000;
    for (int i = 0; i < k; i++) begin
      send_beat((i == 0) ? 64'hAB_123456_DEADBEEF : 64'(i), 8'hFF, i == k - 1);
    end
    idle();
    drain();
    chk("rec_saturated", 128'(last_hdr), 128'({8'hAB, 24'h123456, 32'hDEADBEEF, 16'hFFFF}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
